// File: rtl/fmc_adc_acq_trigger_buffer.sv
// rtl/fmc_adc_acq_trigger_buffer.sv - trigger-qualified circular capture buffer with chronological stream readout
// Ring keeps pre-trigger history; the window is replayed oldest-first through a 1-cycle RAM plus a one-entry skid.
module fmc_adc_acq_trigger_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [63:0]           din,
  input  logic                  din_valid,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  pre_samples,
  input  logic [CNT_WIDTH-1:0]  post_samples,
  output logic [63:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  acq_done,
  output logic                  cfg_err,
  output logic [2:0]            state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH:0] DEPTH_C = {{(CNT_WIDTH-ADDR_WIDTH){1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_FILL  = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_READOUT   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  trigger_d1_q;
  logic                  cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0]  pre_q, pre_d, post_q, post_d;
  logic [CNT_WIDTH-1:0]  fill_cnt_q, fill_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_addr_q, trig_addr_d;
  logic                  trig_pend_q, trig_pend_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [63:0]           dout_q, dout_d, skid_q, skid_d;
  logic                  dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
  logic                  skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;

  logic [63:0]           mem [DEPTH];
  logic [63:0]           mem_rd_q;
  logic                  mem_we, rd_en, rd_last;

  logic                  trig_edge, pop, out_free, cfg_bad;
  logic [CNT_WIDTH:0]    cfg_sum;
  logic [CNT_WIDTH-1:0]  fill_inc, total, total_m1;
  logic [1:0]            occ;

  assign trig_edge = trigger & ~trigger_d1_q;
  assign cfg_sum   = {1'b0, pre_samples} + {1'b0, post_samples};
  assign cfg_bad   = (post_samples == '0) || (cfg_sum > DEPTH_C);
  assign fill_inc  = fill_cnt_q + CNT_WIDTH'(1);
  assign total     = pre_q + post_q;
  assign total_m1  = total - CNT_WIDTH'(1);
  assign pop       = dout_valid_q & dout_ready;
  assign out_free  = ~dout_valid_q | pop;
  // Entries that will sit in output+skid after this edge; a new read may only land if that leaves room.
  assign occ       = {1'b0, dout_valid_q} + {1'b0, skid_valid_q} + {1'b0, rvalid_q} - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    cfg_err_d    = cfg_err_q;
    pre_d        = pre_q;
    post_d       = post_q;
    fill_cnt_d   = fill_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trig_addr_d  = trig_addr_q;
    trig_pend_d  = trig_pend_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    mem_we       = 1'b0;
    rd_en        = 1'b0;
    rd_last      = 1'b0;

    if (abort) begin
      state_d      = S_IDLE;
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_err_d   = 1'b0;
              pre_d       = pre_samples;
              post_d      = post_samples;
              wr_ptr_d    = '0;
              fill_cnt_d  = '0;
              rd_cnt_d    = '0;
              trig_pend_d = 1'b0;
              state_d     = (pre_samples == '0) ? S_WAIT_TRIG : S_PRE_FILL;
            end
          end
        end
        S_PRE_FILL: begin
          if (din_valid) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
            fill_cnt_d = fill_inc;
            if (fill_inc == pre_q) state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_edge) trig_pend_d = 1'b1;
          if (din_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (trig_pend_q || trig_edge) begin
              trig_addr_d = wr_ptr_q;
              rd_ptr_d    = wr_ptr_q - pre_q[ADDR_WIDTH-1:0];
              fill_cnt_d  = CNT_WIDTH'(1);
              trig_pend_d = 1'b0;
              state_d     = (post_q == CNT_WIDTH'(1)) ? S_READOUT : S_POST;
            end
          end
        end
        S_POST: begin
          if (din_valid) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
            fill_cnt_d = fill_inc;
            if (fill_inc == post_q) state_d = S_READOUT;
          end
        end
        S_READOUT: begin
          rd_en   = (rd_cnt_q != total) && (occ < 2'd2);
          rd_last = (rd_cnt_q == total_m1);
          if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
          end
          if (out_free) begin
            if (skid_valid_q) begin
              dout_d       = skid_q;
              dout_last_d  = skid_last_q;
              dout_valid_d = 1'b1;
              skid_valid_d = rvalid_q;
              if (rvalid_q) begin
                skid_d      = mem_rd_q;
                skid_last_d = rlast_q;
              end
            end else if (rvalid_q) begin
              dout_d       = mem_rd_q;
              dout_last_d  = rlast_q;
              dout_valid_d = 1'b1;
            end else begin
              dout_valid_d = 1'b0;
              dout_last_d  = 1'b0;
            end
          end else if (rvalid_q) begin
            skid_d       = mem_rd_q;
            skid_last_d  = rlast_q;
            skid_valid_d = 1'b1;
          end
          if (pop && dout_last_q) begin
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            state_d      = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    rvalid_d = rd_en;
    rlast_d  = rd_last;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      trigger_d1_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      pre_q        <= '0;
      post_q       <= '0;
      fill_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      trig_addr_q  <= '0;
      trig_pend_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      trigger_d1_q <= trigger;
      cfg_err_q    <= cfg_err_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      fill_cnt_q   <= fill_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      trig_addr_q  <= trig_addr_d;
      trig_pend_q  <= trig_pend_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // Plain simple-dual-port RAM: no reset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[wr_ptr_q] <= din;
    if (rd_en)  mem_rd_q <= mem[rd_ptr_q];
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign trig_addr  = trig_addr_q;
  assign cfg_err    = cfg_err_q;
  assign state_o    = state_q;
  assign acq_done   = (state_q == S_DONE);
  assign busy       = (state_q == S_PRE_FILL) || (state_q == S_WAIT_TRIG) ||
                      (state_q == S_POST) || (state_q == S_READOUT);

endmodule

// File: tb/tb_fmc_adc_acq_trigger_buffer.sv
// tb/tb_fmc_adc_acq_trigger_buffer.sv - scoreboard bench for the trigger capture buffer
// Reference keeps the chronological list of written words and slices the window around the trigger word.
module tb_fmc_adc_acq_trigger_buffer;

  localparam int AW = 10;
  localparam int CW = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, din_valid, trigger, arm, abort, dout_ready;
  logic [63:0]   din, dout;
  logic [CW-1:0] pre_samples, post_samples;
  logic          dout_valid, dout_last, busy, acq_done, cfg_err;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  fmc_adc_acq_trigger_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .sys_clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .trigger(trigger),
    .arm(arm), .abort(abort), .pre_samples(pre_samples), .post_samples(post_samples),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .trig_addr(trig_addr), .busy(busy), .acq_done(acq_done), .cfg_err(cfg_err), .state_o(state_o)
  );

  int total = 0, bad = 0, cyc = 0, beats = 0, rdy_mode = 0, exp_state = 0, exp_trig = 0;
  logic [64:0] exp_q[$];
  logic [63:0] hist[$];
  bit          m_active = 0, m_pend = 0, m_prev_trig = 0;
  int          m_pre = 0, m_post = 0, m_n = 0, m_t = -1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got bound expired expected event", nm);
  endtask

  // Applies the currently driven inputs for one clock and advances the reference.
  task automatic cycle();
    bit edge_now;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       dout_ready = 1'($urandom % 2);
      default: dout_ready = 1'b0;
    endcase
    edge_now = trigger && !m_prev_trig;
    m_prev_trig = trigger;
    if (m_active && rst_n && !abort) begin
      if (m_t < 0) begin
        if (m_n >= m_pre && edge_now) m_pend = 1;
        if (din_valid) begin
          if (m_n >= m_pre && m_pend) m_t = m_n;
          hist.push_back(din);
          m_n++;
        end
      end else if (din_valid) begin
        hist.push_back(din);
        m_n++;
      end
      if (m_t >= 0 && m_n == m_t + m_post) begin
        for (int k = 0; k < m_pre + m_post; k++)
          exp_q.push_back({k == m_pre + m_post - 1, hist[m_t - m_pre + k]});
        exp_trig = m_t % DEPTH;
        m_active = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic arm_cfg(input int pre, input int post);
    bit err;
    err = (post == 0) || (pre + post > DEPTH);
    arm = 1; pre_samples = CW'(pre); post_samples = CW'(post); din_valid = 0; trigger = 0;
    cycle();
    arm = 0;
    check("arm_cfg_err", cfg_err, err);
    if (err) begin
      check("arm_state_held", state_o, exp_state);
    end else begin
      check("arm_state", state_o, (pre == 0) ? 2 : 1);
      m_active = 1; m_n = 0; m_t = -1; m_pend = 0; m_pre = pre; m_post = post;
      hist.delete();
      beats = 0;
    end
  endtask

  task automatic feed(input int stop_w, input int e1, input int e2, input int vpct,
                      input bit rnd, input bit idx);
    int w, g;
    w = 0; g = 0;
    while (m_active && (stop_w < 0 || w < stop_w) && g < 20000) begin
      din_valid = ($urandom_range(99) < vpct);
      din = idx ? 64'(w) : {$urandom, $urandom};
      trigger = rnd ? ($urandom_range(5) == 0) : (din_valid && (w == e1 || w == e2));
      if (din_valid) w++;
      cycle();
      g++;
    end
    din_valid = 0;
    trigger = 0;
    if (m_active && stop_w < 0) fail_now("feed_timeout");
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!acq_done && g < 5000) begin
      din_valid = 1'($urandom % 2);
      din = {$urandom, $urandom};
      cycle();
      g++;
    end
    din_valid = 0;
    if (!acq_done) fail_now("readout_timeout");
    check("done_state", state_o, 5);
    check("done_busy", busy, 0);
    check("trig_addr", trig_addr, exp_trig);
    check("all_beats_seen", exp_q.size(), 0);
    check("beat_count", beats, m_pre + m_post);
    exp_state = 5;
  endtask

  task automatic capture(input int pre, input int post, input int e1, input int e2,
                         input int vpct, input bit rnd, input bit idx, input int rmode);
    rdy_mode = rmode;
    arm_cfg(pre, post);
    feed(-1, e1, e2, vpct, rnd, idx);
    wait_done();
    rdy_mode = 0;
  endtask

  bit          stall_prev = 0;
  logic [64:0] held = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) check("stall_hold", {dout_valid, dout_last, dout}, {1'b1, held});
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("beat", {dout_last, dout}, exp_q.pop_front());
        beats++;
      end
    end
    stall_prev = rst_n && dout_valid && !dout_ready && !abort;
    held = {dout_last, dout};
  end

  initial begin
    rst_n = 0; din = '0; din_valid = 0; trigger = 0; arm = 0; abort = 0;
    pre_samples = '0; post_samples = '0; dout_ready = 0;
    repeat (3) cycle();
    rst_n = 1;
    check("reset_outputs", {dout, dout_valid, dout_last, trig_addr, busy, acq_done, cfg_err, state_o}, 0);

    capture(4, 4, 10, -1, 100, 0, 1, 0);
    capture(12, 4, 1030, -1, 100, 0, 1, 0);
    capture(8, 8, 3, 20, 100, 0, 1, 0);
    capture(5, 7, -1, -1, 70, 1, 0, 1);

    arm_cfg(1000, 100);
    arm_cfg(5, 0);
    arm_cfg(1000, 25);
    capture(1000, 24, -1, -1, 90, 1, 0, 2);
    capture(0, 1, -1, -1, 80, 1, 0, 2);

    arm_cfg(4, 20);
    feed(10, 6, -1, 100, 0, 1);
    check("in_post", state_o, 3);
    abort = 1;
    m_active = 0;
    cycle();
    abort = 0;
    check("abort_state", state_o, 0);
    check("abort_valid", dout_valid, 0);
    check("abort_busy", busy, 0);
    exp_state = 0;

    rdy_mode = 3;
    arm_cfg(6, 6);
    feed(-1, -1, -1, 100, 1, 0);
    repeat (4) cycle();
    check("in_readout", state_o, 4);
    check("readout_stalled_valid", dout_valid, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    check("midreadout_reset_outputs",
          {dout, dout_valid, dout_last, trig_addr, busy, acq_done, cfg_err, state_o}, 0);
    exp_q.delete();
    exp_state = 0;
    rdy_mode = 0;

    for (int i = 0; i < 8; i++)
      capture($urandom_range(40), $urandom_range(40, 1), -1, -1, 60, 1, 0, i % 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmc_adc_acq_trigger_buffer.md
Name: fmc_adc_acq_trigger_buffer

Overview:
- Trigger-qualified capture buffer downstream of the 4-channel FMC ADC 250M front end, in the sys_clk domain.
- Consumes the four 16-bit channel samples, already moved to sys_clk by the CDC FIFOs, as one 64-bit word per strobe.
- Keeps a circular pre-trigger history and captures a programmed post-trigger window.
- Streams the window out in chronological order over a valid/ready interface to the DDR3 / host path.

Parameters:
- ADDR_WIDTH, 10: buffer depth = 2^ADDR_WIDTH words of 64 bits.
- CNT_WIDTH, 11: width of pre/post sample-count inputs; must be ADDR_WIDTH+1.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- din  in  64  {adc3[15:0], adc2[15:0], adc1[15:0], adc0[15:0]}.
- din_valid  in  1  one sample word present this cycle.
- trigger  in  1  level input, already synchronous; rising edge detected internally.
- arm  in  1  single-cycle start pulse.
- abort  in  1  single-cycle abort pulse.
- pre_samples  in  CNT_WIDTH  pre-trigger words; sampled on accepted arm.
- post_samples  in  CNT_WIDTH  post-trigger words, including the trigger word; sampled on accepted arm.
- dout  out  64  readout word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts when dout_valid && dout_ready.
- dout_last  out  1  marks the final word of the window.
- trig_addr  out  ADDR_WIDTH  buffer address of the trigger word.
- busy  out  1  high in any state other than IDLE and DONE.
- acq_done  out  1  high in DONE.
- cfg_err  out  1  sticky configuration-error flag.
- state_o  out  3  current state encoding, for debug/Chipscope.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: dout, dout_valid, dout_last, trig_addr, busy, acq_done, cfg_err, state_o.
  - Write pointer, counters and the trigger-edge register are cleared.
  - Reset applied mid-acquisition or mid-readout aborts it immediately; buffer contents become don't-care.
- State encodings: IDLE=0, PRE_FILL=1, WAIT_TRIG=2, POST=3, READOUT=4, DONE=5.
- Trigger edge: trig_edge = trigger & ~trigger_d1. trigger_d1 updates every cycle in every state.
- IDLE / DONE:
  - On arm, pre_samples+post_samples is checked.
  - If post_samples==0 or the sum > 2^ADDR_WIDTH: cfg_err<=1 and the state is held.
  - Otherwise cfg_err<=0, the config is latched, acq_done<=0, the write pointer and counters are cleared, and the next state is PRE_FILL. If pre_samples==0, the next state is WAIT_TRIG directly.
- PRE_FILL:
  - Each din_valid writes din at wr_ptr and increments wr_ptr, wrapping modulo depth.
  - The next state is WAIT_TRIG on the cycle the pre_samples-th word is written.
  - trig_edge is ignored in this state.
- WAIT_TRIG:
  - Each din_valid keeps writing the ring.
  - A trig_edge sets trig_pending.
  - The first din_valid at or after the edge, including the same cycle, is the trigger word:
    - it is written;
    - trig_addr<=wr_ptr;
    - post_cnt<=1;
    - the next state is POST, or READOUT if post_samples==1.
- POST: each din_valid writes and increments post_cnt. The next state is READOUT on the cycle post_cnt reaches post_samples. Trigger edges are ignored.
- READOUT:
  - din_valid is ignored and nothing is written.
  - rd_ptr starts at trig_addr - pre_samples, modulo depth, and wraps modulo depth.
  - Total words read = pre_samples + post_samples.
  - Memory read latency is 1 cycle, with a registered output and a one-entry skid so that dout_valid may stay high back-to-back.
  - While dout_valid && !dout_ready, dout, dout_valid and dout_last hold stable.
  - dout_last is high only with the final word.
  - After the final word is accepted: dout_valid<=0, the next state is DONE, acq_done<=1.
- DONE: holds until arm (starts a new acquisition) or abort.
- abort in any state: next state IDLE, dout_valid<=0, acq_done<=0. cfg_err is unchanged. abort takes priority over arm in the same cycle.
- arm outside IDLE/DONE is ignored.
- busy = state is PRE_FILL, WAIT_TRIG, POST or READOUT.
- Buffer memory is inferable as a simple dual-port block RAM, with write and read on sys_clk.

Test Plan:
- pre=4, post=4, din=incrementing word index from 0:
  - arm; feed 10 words; trigger edge together with word 10; feed to word 13.
  - Readout must be words 6..13; dout_last on word 13; trig_addr=10; acq_done=1 afterwards.
- ADDR_WIDTH=4 (depth 16), pre=12, post=4:
  - feed 40 words; trigger at word 30.
  - Readout must be 18..33 in order across the pointer wrap; trig_addr=(30 mod 16)=14.
- Trigger edge during PRE_FILL (pre=8, edge on word 3), then edge on word 20:
  - capture must use word 20; first output word = 12.
- Readout backpressure: dout_ready toggles 1,0,0,1 repeating:
  - no word is lost or duplicated; dout is stable while stalled; exactly pre+post beats.
- Config errors:
  - arm with pre=1000, post=100 at ADDR_WIDTH=10 → cfg_err=1, state stays IDLE.
  - arm with post=0 → cfg_err=1, state stays IDLE.
  - Valid re-arm → cfg_err=0.
- Interrupts:
  - abort in POST → state_o=0 the next cycle.
  - rst_n=0 for 1 cycle in READOUT → all outputs 0 the next cycle.
  - Subsequent arm and capture complete correctly.
